add2bit: RTL and testbench

Registered two-operand binary adder with carry-in and carry-out. The default width is 2 bits. It serves as the basic arithmetic slice in the adders library. Slices chain for multi-word addition by feeding a registered c_out back into c_in on the next cycle. Operands are sampled on a qualifying clock edge, and the result appears one cycle later.

---
 rtl/add2bit.sv | 108 ++++++++++
 tb/tb_add2bit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/add2bit.sv
// add2bit -- registered WIDTH-bit ripple-carry adder slice with carry in/out.
//
// Operands are captured on a rising clk edge where in_valid is high; the
// result is registered at that same edge, so it is visible one cycle after
// the operands were presented. When in_valid is low the result registers
// hold their value and out_valid drops.
//
// Because c_in only feeds the sum/carry registers, c_out may be wired
// straight back to c_in for multi-word chaining without creating a
// combinational loop. The carry of word k is then absorbed by word k+1 on
// the following cycle.
//
// Optional build macro: ADD2BIT_OVF_EN
//   When defined, adds the registered output ovf. This is the
//   two's-complement signed overflow flag (carry into MSB ^ carry out of
//   MSB).
//
// Parameters:
//   WIDTH     operand / sum width, 1..32 (default 2)
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset; has priority over in_valid
//   in_valid  capture a, b, c_in this edge
//   a, b      operands (WIDTH bits)
//   c_in      carry into bit 0
//   sum       registered {a+b+c_in}[WIDTH-1:0]
//   c_out     registered carry out of bit WIDTH-1
//   out_valid registered, high for one cycle after each capture
//   ovf       (ADD2BIT_OVF_EN only) registered signed overflow

// One full-adder stage of the ripple chain.
module add2bit_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module add2bit #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             out_valid
`ifdef ADD2BIT_OVF_EN
  ,
  output logic             ovf
`endif
);

  // carry[i] is the carry into stage i; carry[WIDTH] is the carry out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_nxt;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    add2bit_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_nxt[i]),
      .co (carry[i+1])
    );
  end

  // Result registers. They only load on a qualified edge, so idle cycles
  // keep the last result for consumers that sample late.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else if (in_valid) begin
      sum   <= sum_nxt;
      c_out <= carry[WIDTH];
    end
  end

  // Single-stage valid pipe. This follows in_valid directly and does not
  // hold, so out_valid is a one-cycle strobe per capture.
  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= in_valid;
  end

`ifdef ADD2BIT_OVF_EN
  // Signed overflow occurs when the carry into the sign bit differs from
  // the carry out of it.
  logic ovf_nxt;
  assign ovf_nxt = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst)           ovf <= 1'b0;
    else if (in_valid) ovf <= ovf_nxt;
  end
`endif

endmodule

// File: tb/tb_add2bit.sv
module tb_add2bit;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         cin_r;
  logic         fb;
  logic         c_in;
  logic [W-1:0] sum;
  logic         c_out;
  logic         out_valid;
`ifdef ADD2BIT_OVF_EN
  logic         ovf;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // fb=1 ties c_in to the registered c_out, exercising the chaining path.
  assign c_in = fb ? c_out : cin_r;

  always #5 clk = ~clk;

  add2bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sum       (sum),
    .c_out     (c_out),
    .out_valid (out_valid)
`ifdef ADD2BIT_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv);
    in_valid = v; a = av; b = bv; cin_r = cv;
  endtask

  initial begin
    fb = 1'b0;
    // Reset held two cycles with live operands: outputs stay cleared.
    rst = 1'b1;
    drive(1'b1, 2'd3, 2'd3, 1'b1);
    tick();
    chk("rst1_sum", 32'(sum), 32'd0);
    chk("rst1_cout", 32'(c_out), 32'd0);
    chk("rst1_vld", 32'(out_valid), 32'd0);
    tick();
    chk("rst2_sum", 32'(sum), 32'd0);
    chk("rst2_vld", 32'(out_valid), 32'd0);
`ifdef ADD2BIT_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    tick();
    // 3+3+1 = 7 -> sum 3, carry 1
    chk("post_rst_sum", 32'(sum), 32'd3);
    chk("post_rst_cout", 32'(c_out), 32'd1);
    chk("post_rst_vld", 32'(out_valid), 32'd1);

    // Hand-picked examples.
    drive(1'b1, 2'd2, 2'd1, 1'b0); tick();
    chk("ex_2p1_sum", 32'(sum), 32'd3);
    chk("ex_2p1_cout", 32'(c_out), 32'd0);
    drive(1'b1, 2'd3, 2'd1, 1'b0); tick();
    chk("ex_3p1_sum", 32'(sum), 32'd0);
    chk("ex_3p1_cout", 32'(c_out), 32'd1);
    drive(1'b1, 2'd0, 2'd0, 1'b0); tick();
    chk("zero_sum", 32'(sum), 32'd0);
    chk("zero_cout", 32'(c_out), 32'd0);
    drive(1'b1, 2'd3, 2'd3, 1'b1); tick();
    chk("ones_sum", 32'(sum), 32'd3);
    chk("ones_cout", 32'(c_out), 32'd1);

    // Exhaustive sweep, back-to-back.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 2; k++) begin
          drive(1'b1, W'(i), W'(j), k[0]);
          tick();
          chk($sformatf("sweep_%0d_%0d_%0d", i, j, k), {29'd0, c_out, sum}, 32'(i + j + k));
          chk($sformatf("sweep_vld_%0d_%0d_%0d", i, j, k), 32'(out_valid), 32'd1);
        end

    // Hold: capture 1+1, then idle with different operands.
    drive(1'b1, 2'd1, 2'd1, 1'b0); tick();
    chk("hold_cap_sum", 32'(sum), 32'd2);
    drive(1'b0, 2'd3, 2'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_sum_%0d", i), 32'(sum), 32'd2);
      chk($sformatf("hold_cout_%0d", i), 32'(c_out), 32'd0);
      chk($sformatf("hold_vld_%0d", i), 32'(out_valid), 32'd0);
    end

    // Carry feedback: c_out is 0 entering this sequence.
    fb = 1'b1;
    drive(1'b1, 2'd3, 2'd1, 1'b0); tick();
    chk("fb0_sum", 32'(sum), 32'd0);
    chk("fb0_cout", 32'(c_out), 32'd1);
    drive(1'b1, 2'd0, 2'd0, 1'b0); tick();
    chk("fb1_sum", 32'(sum), 32'd1);
    chk("fb1_cout", 32'(c_out), 32'd0);
    drive(1'b1, 2'd1, 2'd1, 1'b0); tick();
    chk("fb2_sum", 32'(sum), 32'd2);
    chk("fb2_cout", 32'(c_out), 32'd0);
    fb = 1'b0;

`ifdef ADD2BIT_OVF_EN
    drive(1'b1, 2'd1, 2'd1, 1'b0); tick();
    chk("ovf_1p1", 32'(ovf), 32'd1);
    drive(1'b1, 2'd2, 2'd2, 1'b0); tick();
    chk("ovf_2p2_sum", 32'(sum), 32'd0);
    chk("ovf_2p2_cout", 32'(c_out), 32'd1);
    chk("ovf_2p2", 32'(ovf), 32'd1);
    drive(1'b0, 2'd0, 2'd0, 1'b0); tick();
    chk("ovf_hold", 32'(ovf), 32'd1);
    drive(1'b1, 2'd3, 2'd3, 1'b0); tick();
    chk("ovf_3p3_sum", 32'(sum), 32'd2);
    chk("ovf_3p3_cout", 32'(c_out), 32'd1);
    chk("ovf_3p3", 32'(ovf), 32'd0);
`endif

    // Back-to-back after an idle cycle.
    drive(1'b0, 2'd0, 2'd0, 1'b0); tick();
    chk("b2b_idle_vld", 32'(out_valid), 32'd0);
    drive(1'b1, 2'd0, 2'd0, 1'b0); tick();
    chk("b2b0_sum", 32'(sum), 32'd0);
    chk("b2b0_cout", 32'(c_out), 32'd0);
    chk("b2b0_vld", 32'(out_valid), 32'd1);
    drive(1'b1, 2'd3, 2'd3, 1'b1); tick();
    chk("b2b1_sum", 32'(sum), 32'd3);
    chk("b2b1_cout", 32'(c_out), 32'd1);
    chk("b2b1_vld", 32'(out_valid), 32'd1);

    // Mid-stream reset beats in_valid and discards the result.
    drive(1'b1, 2'd2, 2'd1, 1'b0);
    rst = 1'b1; tick();
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(c_out), 32'd0);
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    rst = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 1'b0); tick();
    chk("mid_rst_after_vld", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
